// File: rtl/cdb_pkg.sv
// ============================================================================
// Module      : cdb_pkg
// Description : Shared widths, lane record and source indices for the CDB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_pkg;

    localparam int CDB_TAG_W  = 5;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_SRC_W  = 3;

    localparam int SRC_ADD   = 0;
    localparam int SRC_LOGIC = 1;
    localparam int SRC_MUL   = 2;
    localparam int SRC_LOAD  = 3;
    localparam int SRC_STORE = 4;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] val;
        logic [CDB_SRC_W-1:0]  src;
    } cdb_lane_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Returns the first set mask bit at or after i_ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    logic [IW-1:0] w_pos;

    // Scan from the farthest offset down so the nearest hit overwrites the rest.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        w_pos    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = IW'((int'(i_ptr) + k) % N);
            if (i_mask[w_pos]) begin
                o_onehot        = '0;
                o_onehot[w_pos] = 1'b1;
                o_idx           = w_pos;
                o_vld           = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_rr_arbiter.sv
// ============================================================================
// Module      : cdb_rr_arbiter
// Description : Round-robin common data bus, NUM_SRC requesters onto NUM_BUSES lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = 5,
    parameter int NUM_BUSES = 2,
    parameter int TAG_W     = CDB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W,
    localparam int SW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [NUM_SRC*TAG_W-1:0]    tag_in,
    input  logic [NUM_SRC*DATA_W-1:0]   val_in,
    output logic [NUM_SRC-1:0]          grant,
    output logic [NUM_BUSES-1:0]        bc_valid,
    output logic [NUM_BUSES*TAG_W-1:0]  bc_tag,
    output logic [NUM_BUSES*DATA_W-1:0] bc_val,
    output logic [NUM_BUSES*SW-1:0]     bc_src
);

    logic [NUM_BUSES:0][NUM_SRC-1:0]   w_mask;
    logic [NUM_BUSES-1:0][NUM_SRC-1:0] w_pick;
    logic [NUM_BUSES-1:0][SW-1:0]      w_idx;
    logic [NUM_BUSES-1:0]              w_vld;
    logic [NUM_BUSES-1:0][TAG_W-1:0]   w_lane_tag;
    logic [NUM_BUSES-1:0][DATA_W-1:0]  w_lane_val;
    logic [SW-1:0]                     w_ptr_nxt;
    logic                              w_active;

    logic [SW-1:0]                     r_ptr;
    logic [NUM_BUSES-1:0]              r_valid;
    logic [NUM_BUSES*TAG_W-1:0]        r_tag;
    logic [NUM_BUSES*DATA_W-1:0]       r_val;
    logic [NUM_BUSES*SW-1:0]           r_src;

    assign w_active  = rst_n & ~flush;
    assign w_mask[0] = req;

    // Each stage sees the requests left over after all earlier lanes picked.
    generate
        for (genvar k = 0; k < NUM_BUSES; k++) begin : g_lane
            rr_pick #(
                .N  (NUM_SRC),
                .IW (SW)
            ) u_pick (
                .i_mask   (w_mask[k]),
                .i_ptr    (r_ptr),
                .o_onehot (w_pick[k]),
                .o_idx    (w_idx[k]),
                .o_vld    (w_vld[k])
            );
            assign w_mask[k+1] = w_mask[k] & ~w_pick[k];
        end
    endgenerate

    assign grant = w_active ? (req & ~w_mask[NUM_BUSES]) : '0;

    always_comb begin
        w_lane_tag = '0;
        w_lane_val = '0;
        for (int k = 0; k < NUM_BUSES; k++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                w_lane_tag[k] = w_lane_tag[k] | ({TAG_W{w_pick[k][s]}}  & tag_in[s*TAG_W +: TAG_W]);
                w_lane_val[k] = w_lane_val[k] | ({DATA_W{w_pick[k][s]}} & val_in[s*DATA_W +: DATA_W]);
            end
        end
    end

    // Pointer moves just past the highest-numbered lane's winner.
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < NUM_BUSES; k++) begin
            if (w_vld[k]) begin
                w_ptr_nxt = (w_idx[k] == SW'(NUM_SRC - 1)) ? '0 : w_idx[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_valid <= '0;
            r_tag   <= '0;
            r_val   <= '0;
            r_src   <= '0;
        end else begin
            if (!flush) begin
                r_ptr <= w_ptr_nxt;
            end
            for (int k = 0; k < NUM_BUSES; k++) begin
                r_valid[k] <= w_vld[k] & ~flush;
                if (w_vld[k] && !flush) begin
                    r_tag[k*TAG_W +: TAG_W]   <= w_lane_tag[k];
                    r_val[k*DATA_W +: DATA_W] <= w_lane_val[k];
                    r_src[k*SW +: SW]         <= w_idx[k];
                end
            end
        end
    end

    assign bc_valid = r_valid;
    assign bc_tag   = r_tag;
    assign bc_val   = r_val;
    assign bc_src   = r_src;

endmodule

`default_nettype wire

// File: tb/tb_cdb_rr_arbiter.sv
// ============================================================================
// Module      : tb_cdb_rr_arbiter
// Description : Directed self-checking bench for the round-robin CDB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_rr_arbiter;

    localparam int NS = 5;
    localparam int NB = 2;
    localparam int TW = 5;
    localparam int DW = 32;
    localparam int SW = 3;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [NS-1:0]     req   = '0;
    logic [NS*TW-1:0]  tag_in = '0;
    logic [NS*DW-1:0]  val_in = '0;
    logic [NS-1:0]     grant;
    logic [NB-1:0]     bc_valid;
    logic [NB*TW-1:0]  bc_tag;
    logic [NB*DW-1:0]  bc_val;
    logic [NB*SW-1:0]  bc_src;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt [NS];
    logic [NS-1:0] fair_exp [5];

    cdb_rr_arbiter #(
        .NUM_SRC   (NS),
        .NUM_BUSES (NB),
        .TAG_W     (TW),
        .DATA_W    (DW)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .req      (req),
        .tag_in   (tag_in),
        .val_in   (val_in),
        .grant    (grant),
        .bc_valid (bc_valid),
        .bc_tag   (bc_tag),
        .bc_val   (bc_val),
        .bc_src   (bc_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
        tag_in[i*TW +: TW] = t;
        val_in[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        req   = '1;
        #1;
        check("rst_grant", 32'(grant), 0);
        tick();
        tick();
        check("rst_valid", 32'(bc_valid), 0);
        check("rst_tag",   32'(bc_tag),   0);
        check("rst_val0",  bc_val[31:0],  0);
        check("rst_src",   32'(bc_src),   0);
        rst_n = 1'b1;
        req   = '0;
    endtask

    initial begin
        fair_exp[0] = 5'b00011;
        fair_exp[1] = 5'b01100;
        fair_exp[2] = 5'b10001;
        fair_exp[3] = 5'b00110;
        fair_exp[4] = 5'b11000;
        for (int s = 0; s < NS; s++) set_src(s, TW'(20 + s), DW'(100 + s));

        // reset
        do_reset();

        // single request, then pointer probe (ptr should be 2)
        set_src(1, 5'd3, 32'd7);
        req = 5'b00010;
        #1;
        check("single_grant", 32'(grant), 'b00010);
        tick();
        req = '0;
        #1;
        check("single_grant_off", 32'(grant), 0);
        check("single_valid", 32'(bc_valid), 'b01);
        check("single_tag0",  32'(bc_tag[4:0]), 3);
        check("single_val0",  bc_val[31:0], 7);
        check("single_src0",  32'(bc_src[2:0]), 1);
        req = 5'b00101;
        #1;
        check("probe1_grant", 32'(grant), 'b00101);
        tick();
        req = '0;
        #1;
        check("probe1_src0", 32'(bc_src[2:0]), 2);
        check("probe1_src1", 32'(bc_src[5:3]), 0);

        // three requesters over two cycles
        do_reset();
        set_src(0, 5'd5, 32'd1);
        set_src(1, 5'd3, 32'd2);
        set_src(3, 5'd9, 32'd15);
        req = 5'b01011;
        #1;
        check("three_grant_t0", 32'(grant), 'b00011);
        tick();
        req = 5'b01000;
        #1;
        check("three_grant_t1", 32'(grant), 'b01000);
        check("three_valid_t1", 32'(bc_valid), 'b11);
        check("three_tag0_t1",  32'(bc_tag[4:0]), 5);
        check("three_val0_t1",  bc_val[31:0], 1);
        check("three_tag1_t1",  32'(bc_tag[9:5]), 3);
        check("three_src1_t1",  32'(bc_src[5:3]), 1);
        tick();
        req = '0;
        #1;
        check("three_valid_t2", 32'(bc_valid), 'b01);
        check("three_tag0_t2",  32'(bc_tag[4:0]), 9);
        check("three_val0_t2",  bc_val[31:0], 15);
        check("three_src0_t2",  32'(bc_src[2:0]), 3);
        check("three_tag1_hold", 32'(bc_tag[9:5]), 3);
        req = 5'b10001;
        #1;
        check("probe2_grant", 32'(grant), 'b10001);
        tick();
        req = '0;
        #1;
        check("probe2_src0", 32'(bc_src[2:0]), 4);
        check("probe2_src1", 32'(bc_src[5:3]), 0);

        // fairness with all sources requesting continuously
        do_reset();
        for (int s = 0; s < NS; s++) cnt[s] = 0;
        req = '1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("fair_grant_c%0d", c), 32'(grant), 32'(fair_exp[c % 5]));
            for (int s = 0; s < NS; s++) cnt[s] += int'(grant[s]);
            tick();
        end
        req = '0;
        for (int s = 0; s < NS; s++) check($sformatf("fair_count_s%0d", s), cnt[s], 4);

        // flush
        do_reset();
        req = 5'b00001;
        #1;
        check("flush_pre_grant", 32'(grant), 'b00001);
        tick();
        flush = 1'b1;
        req   = 5'b00100;
        #1;
        check("flush_grant", 32'(grant), 0);
        check("flush_inflight_valid", 32'(bc_valid), 'b01);
        tick();
        #1;
        check("flush_next_valid", 32'(bc_valid), 0);
        flush = 1'b0;
        req   = 5'b00101;
        #1;
        check("flush_after_grant", 32'(grant), 'b00101);
        tick();
        req = '0;
        #1;
        check("flush_ptr_src0", 32'(bc_src[2:0]), 2);
        check("flush_ptr_src1", 32'(bc_src[5:3]), 0);
        check("flush_after_valid", 32'(bc_valid), 'b11);

        // reset while a lane is valid
        do_reset();
        req = 5'b00010;
        #1;
        check("midrst_grant", 32'(grant), 'b00010);
        tick();
        req = '0;
        #1;
        check("midrst_pre_valid", 32'(bc_valid), 'b01);
        rst_n = 1'b0;
        req   = '1;
        #1;
        check("midrst_grant_low", 32'(grant), 0);
        tick();
        #1;
        check("midrst_valid", 32'(bc_valid), 0);
        check("midrst_src",   32'(bc_src), 0);
        rst_n = 1'b1;
        req   = 5'b00110;
        #1;
        check("midrst_probe_grant", 32'(grant), 'b00110);
        tick();
        req = '0;
        #1;
        check("midrst_ptr_src0", 32'(bc_src[2:0]), 1);
        check("midrst_ptr_src1", 32'(bc_src[5:3]), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
